mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF-stage instruction fetch port and the MEM-stage data port.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
//   arb_state_t : arbiter sequencing states (idle, access in flight, response cycle)
//   owner_t     : which pipeline port owns the current memory access
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IF-stage fetch port
// (i_*) and the MEM-stage data port (d_*). Each access runs IDLE -> BUSY -> RESP.
// Data has priority over fetch, except that fetch is forced after MAX_D_STREAK
// consecutive data grants taken while fetch was waiting. A BUSY phase with no
// m_ack for TIMEOUT cycles is aborted and answered with err=1, rdata=0.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req/i_addr                  fetch request, held until i_rvalid
//   i_gnt/i_rvalid/i_rdata/i_err  fetch accept pulse, completion pulse, data, timeout flag
//   i_stall                       i_req & ~i_rvalid
//   d_req/d_we/d_addr/d_wdata     data request, held until d_rvalid
//   d_gnt/d_rvalid/d_rdata/d_err  data accept pulse, completion pulse, load data, timeout flag
//   d_stall                       d_req & ~d_rvalid
//   m_req/m_we/m_addr/m_wdata     memory request, held until m_ack
//   m_ack/m_rdata                 memory completion and read data (same cycle)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] S_MAX  = SW'(MAX_D_STREAK);
    // Abort fires in the TIMEOUT-th BUSY cycle, i.e. when the count of
    // ack-less cycles already seen equals TIMEOUT-1.
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t    state;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          fetch_forced;

    assign i_stall      = i_req & ~i_rvalid;
    assign d_stall      = d_req & ~d_rvalid;
    assign fetch_forced = i_req && (streak == S_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= OWN_I;
            streak   <= '0;
            tcnt     <= '0;
            i_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_gnt    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (i_req || d_req) begin
                        if (d_req && !fetch_forced) begin
                            owner   <= OWN_D;
                            m_addr  <= d_addr;
                            m_we    <= d_we;
                            m_wdata <= d_wdata;
                            d_gnt   <= 1'b1;
                            // Streak only counts grants that made fetch wait.
                            if (!i_req)
                                streak <= '0;
                            else if (streak != S_MAX)
                                streak <= streak + SW'(1);
                        end else begin
                            owner   <= OWN_I;
                            m_addr  <= i_addr;
                            m_we    <= 1'b0;
                            m_wdata <= '0;
                            i_gnt   <= 1'b1;
                            streak  <= '0;
                        end
                        m_req <= 1'b1;
                        tcnt  <= '0;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // A real ack beats a same-cycle timeout abort.
                    if (m_ack) begin
                        m_req <= 1'b0;
                        state <= ARB_RESP;
                        if (owner == OWN_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= m_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            if (!m_we)
                                d_rdata <= m_rdata;
                        end
                    end else if ((TIMEOUT != 0) && (tcnt == T_LAST)) begin
                        m_req <= 1'b0;
                        state <= ARB_RESP;
                        if (owner == OWN_I) begin
                            i_rvalid <= 1'b1;
                            i_err    <= 1'b1;
                            i_rdata  <= '0;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= '0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // The owning requester must keep its request up for the whole access.
    req_held_while_busy: assert property (
        @(posedge clk) disable iff (rst)
        (state == ARB_BUSY) |-> ((owner == OWN_I) ? i_req : d_req)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes hand-computed
// expected grants, memory transactions and responses into queues; independent
// monitor processes pop and compare them whenever the DUT presents them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_err, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { bit port; logic [31:0] rdata; bit err; int cyc; } resp_t;   // port 1 = data
    typedef struct { bit port; int cyc; } gnt_t;
    typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; int len; } mtx_t;

    resp_t exp_resp[$];
    gnt_t  exp_gnt[$];
    mtx_t  exp_mem[$];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: acks ack_delay cycles after m_req is first seen.
    int ack_delay = 1;
    bit mem_on    = 1'b1;
    bit stray_ack = 1'b0;
    initial begin
        int wcnt;
        wcnt    = 0;
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = stray_ack;
            if (stray_ack) m_rdata = 32'hBAD0_BAD0;
            if (m_req && mem_on) begin
                if (wcnt == ack_delay) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_val(m_addr);
                    wcnt    = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Grant and response monitor.
    initial begin
        gnt_t  g;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (i_gnt || d_gnt) begin
                    if (i_gnt && d_gnt) chk("gnt_both", 64'(1), 64'(0));
                    else if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(1), 64'(0));
                    else begin
                        g = exp_gnt.pop_front();
                        chk("gnt_owner", 64'(d_gnt), 64'(g.port));
                        if (g.cyc >= 0) chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
                    end
                end
                if (i_rvalid || d_rvalid) begin
                    if (i_rvalid && d_rvalid) chk("rvalid_both", 64'(1), 64'(0));
                    else if (exp_resp.size() == 0) chk("rvalid_unexpected", 64'(1), 64'(0));
                    else begin
                        r = exp_resp.pop_front();
                        chk("resp_port", 64'(d_rvalid), 64'(r.port));
                        chk("resp_rdata", 64'(d_rvalid ? d_rdata : i_rdata), 64'(r.rdata));
                        chk("resp_err", 64'(d_rvalid ? d_err : i_err), 64'(r.err));
                        if (r.cyc >= 0) chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end
            end
        end
    end

    // Memory-side monitor: address/we/wdata per access, m_req high length.
    initial begin
        mtx_t cur;
        bit   prev;
        int   mlen;
        prev = 1'b0;
        mlen = 0;
        cur  = '{addr: '0, we: 1'b0, wdata: '0, len: -1};
        forever begin
            @(negedge clk);
            if (m_req && !prev) begin
                mlen = 1;
                if (exp_mem.size() == 0) begin
                    chk("m_req_unexpected", 64'(1), 64'(0));
                    cur = '{addr: m_addr, we: m_we, wdata: m_wdata, len: -1};
                end else begin
                    cur = exp_mem.pop_front();
                    chk("m_addr", 64'(m_addr), 64'(cur.addr));
                    chk("m_we", 64'(m_we), 64'(cur.we));
                    if (cur.we) chk("m_wdata", 64'(m_wdata), 64'(cur.wdata));
                end
            end else if (m_req) begin
                mlen++;
                chk("m_addr_stable", 64'(m_addr), 64'(cur.addr));
            end
            if (!m_req && prev && cur.len >= 0) chk("m_req_len", 64'(mlen), 64'(cur.len));
            prev = m_req;
        end
    end

    task automatic wait_rv(input bit port);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (port ? d_rvalid : i_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(port ? "d_rvalid_wait" : "i_rvalid_wait", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        i_addr = a;
        i_req  = 1'b1;
        wait_rv(1'b0);
        i_req  = 1'b0;
    endtask

    task automatic dacc(input bit we, input logic [31:0] a, input logic [31:0] wd);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        wait_rv(1'b1);
        d_req   = 1'b0;
    endtask

    function automatic void push_access(input bit port, input logic [31:0] a, input bit we,
                                        input logic [31:0] wd, input int len,
                                        input logic [31:0] rd, input bit err,
                                        input int gcyc, input int rcyc);
        exp_gnt.push_back('{port: port, cyc: gcyc});
        exp_mem.push_back('{addr: a, we: we, wdata: wd, len: len});
        exp_resp.push_back('{port: port, rdata: rd, err: err, cyc: rcyc});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  seen;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we}), 64'(0));
        chk("rst_i_rdata", 64'(i_rdata), 64'(0));
        chk("rst_d_rdata", 64'(d_rdata), 64'(0));
        chk("rst_m_addr", 64'(m_addr), 64'(0));
        chk("rst_m_wdata", 64'(m_wdata), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. single fetch with exact latency and stall profile
        n0 = cyc;
        push_access(1'b0, 32'h10, 1'b0, '0, 2, 32'h0050_0093, 1'b0, n0 + 1, n0 + 3);
        fork
            fetch(32'h10);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk($sformatf("t1_i_stall_%0d", k), 64'(i_stall), (k < 3) ? 64'd1 : 64'd0);
                end
            end
        join

        // 2. simultaneous requests: data first
        push_access(1'b1, 32'h100, 1'b0, '0, -1, 32'h0100_FEFF, 1'b0, -1, -1);
        push_access(1'b0, 32'h40,  1'b0, '0, -1, 32'h0040_FFBF, 1'b0, -1, -1);
        fork
            fetch(32'h40);
            dacc(1'b0, 32'h100, '0);
        join

        // 3. starvation: D,D,D,D,I,D,D
        for (int k = 0; k < 4; k++)
            push_access(1'b1, 32'h104 + 32'(4 * k), 1'b0, '0, -1, mem_val(32'h104 + 32'(4 * k)), 1'b0, -1, -1);
        push_access(1'b0, 32'h80, 1'b0, '0, -1, 32'h0080_FF7F, 1'b0, -1, -1);
        push_access(1'b1, 32'h114, 1'b0, '0, -1, 32'h0114_FEEB, 1'b0, -1, -1);
        push_access(1'b1, 32'h118, 1'b0, '0, -1, 32'h0118_FEE7, 1'b0, -1, -1);
        fork
            fetch(32'h80);
            for (int k = 0; k < 6; k++) dacc(1'b0, 32'h104 + 32'(4 * k), '0);
        join

        // 4. store: d_rdata keeps the previous load value
        push_access(1'b1, 32'h20, 1'b1, 32'hDEAD_BEEF, 2, 32'h0118_FEE7, 1'b0, -1, -1);
        dacc(1'b1, 32'h20, 32'hDEAD_BEEF);

        // 5. timeout after 8 BUSY cycles, then a normal slow access
        mem_on = 1'b0;
        push_access(1'b1, 32'h200, 1'b0, '0, 8, 32'h0, 1'b1, -1, -1);
        dacc(1'b0, 32'h200, '0);
        mem_on = 1'b1;
        ack_delay = 5;
        push_access(1'b0, 32'h44, 1'b0, '0, 6, 32'h0044_FFBB, 1'b0, -1, -1);
        fetch(32'h44);
        ack_delay = 1;

        // 6. reset in the middle of an access
        mem_on = 1'b0;
        exp_gnt.push_back('{port: 1'b1, cyc: -1});
        exp_mem.push_back('{addr: 32'h300, we: 1'b0, wdata: '0, len: -1});
        d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_m_req_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_m_req_async_drop", 64'(m_req), 64'(0));
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mem_on = 1'b1;
        stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_d_rdata_after_stray", 64'(d_rdata), 64'(0));
        chk("t6_i_rdata_after_stray", 64'(i_rdata), 64'(0));
        @(posedge clk);
        #1;
        n0 = cyc;
        push_access(1'b0, 32'h10, 1'b0, '0, 2, 32'h0050_0093, 1'b0, n0 + 1, n0 + 3);
        fetch(32'h10);
        push_access(1'b1, 32'h124, 1'b0, '0, 2, 32'h0124_FEDB, 1'b0, -1, -1);
        dacc(1'b0, 32'h124, '0);

        repeat (5) @(negedge clk);
        chk("left_gnt", 64'(exp_gnt.size()), 64'(0));
        chk("left_mem", 64'(exp_mem.size()), 64'(0));
        chk("left_resp", 64'(exp_resp.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
